// File: rtl/gpu_def.sv
// ============================================================================
// Package     : gpu_def
// Description : Shared GPU constants (VRAM->CPU FIFO depth, GPUSTAT bit index)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_def;

    localparam int FIFO_DEPTH_LOG2        = 4;
    localparam int GPUSTAT_READY_VRAM2CPU = 27;

endpackage

`default_nettype wire

// File: rtl/gpu_fifo_dpram.sv
// ============================================================================
// Module      : gpu_fifo_dpram
// Description : Simple dual-port RAM, one write port, one registered read port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_fifo_dpram
    import gpu_def::*;
#(
    parameter int ADDR_W = FIFO_DEPTH_LOG2,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W-1:0] wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdData_q;

    // Read-before-write: a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

`default_nettype wire

// File: rtl/gpu_vram2cpu_outfifo.sv
// ============================================================================
// Module      : gpu_vram2cpu_outfifo
// Description : VRAM->CPU copy output FIFO feeding GPUREAD and GPUSTAT.27
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_vram2cpu_outfifo
    import gpu_def::*;
#(
    parameter int DEPTH_LOG2      = FIFO_DEPTH_LOG2,
    parameter int CAN_PUSH_MARGIN = 2,
    parameter int NEAR_MARGIN     = 4
)(
    input  logic        clk,
    input  logic        nRst,
    input  logic        i_flush,
    input  logic        i_write,
    input  logic [31:0] i_writeData,
    output logic        o_canPush,
    output logic        o_canNearPush,
    output logic        o_empty,
    input  logic        i_cpuRead,
    output logic [31:0] o_cpuData,
    input  logic        i_infoWrite,
    input  logic [31:0] i_infoData,
    output logic        o_readyToSend,
    output logic        o_overflow
);

    localparam int                  c_DEPTH_INT   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH       = (DEPTH_LOG2+1)'(c_DEPTH_INT);
    localparam logic [DEPTH_LOG2:0] c_PUSH_MARGIN = (DEPTH_LOG2+1)'(CAN_PUSH_MARGIN);
    localparam logic [DEPTH_LOG2:0] c_NEAR_MARGIN = (DEPTH_LOG2+1)'(NEAR_MARGIN);

    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           cpuData_q, cpuData_d;
    logic                  useRam_q, useRam_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_popOk;
    logic                  w_pushOk;
    logic [DEPTH_LOG2:0]   w_free;
    logic [31:0]           w_ramData;

    assign w_full   = (count_q == c_DEPTH);
    assign w_empty  = (count_q == '0);
    assign w_free   = c_DEPTH - count_q;
    assign w_popOk  = i_cpuRead && !w_empty && !i_flush;
    // A pop in the same cycle frees the slot this push lands in.
    assign w_pushOk = i_write && (!w_full || w_popOk) && !i_flush;

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cpuData_d  = cpuData_q;
        useRam_d   = useRam_q;

        if (i_flush) begin
            rdPtr_d    = '0;
            wrPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_pushOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (w_popOk) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            if (i_write && !w_pushOk) begin
                overflow_d = 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // GPUREAD source: the info latch wins over a same-cycle pop.
        if (i_infoWrite) begin
            cpuData_d = i_infoData;
            useRam_d  = 1'b0;
        end else if (w_popOk) begin
            useRam_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cpuData_q  <= '0;
            useRam_q   <= 1'b0;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cpuData_q  <= cpuData_d;
            useRam_q   <= useRam_d;
        end
    end

    gpu_fifo_dpram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (w_pushOk),
        .wrAddr_i (wrPtr_q),
        .wrData_i (i_writeData),
        .rdEn_i   (w_popOk),
        .rdAddr_i (rdPtr_q),
        .rdData_o (w_ramData)
    );

    assign o_cpuData     = useRam_q ? w_ramData : cpuData_q;
    assign o_empty       = w_empty;
    assign o_readyToSend = !w_empty;
    assign o_canPush     = (w_free >= c_PUSH_MARGIN);
    assign o_canNearPush = (w_free >= c_NEAR_MARGIN);
    assign o_overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_gpu_vram2cpu_outfifo.sv
// ============================================================================
// Module      : tb_gpu_vram2cpu_outfifo
// Description : Scoreboard bench for the VRAM->CPU output FIFO
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_vram2cpu_outfifo;

    logic        clk;
    logic        nRst;
    logic        i_flush;
    logic        i_write;
    logic [31:0] i_writeData;
    logic        o_canPush;
    logic        o_canNearPush;
    logic        o_empty;
    logic        i_cpuRead;
    logic [31:0] o_cpuData;
    logic        i_infoWrite;
    logic [31:0] i_infoData;
    logic        o_readyToSend;
    logic        o_overflow;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];
    logic        r_rdSeen;

    gpu_vram2cpu_outfifo u_dut (
        .clk           (clk),
        .nRst          (nRst),
        .i_flush       (i_flush),
        .i_write       (i_write),
        .i_writeData   (i_writeData),
        .o_canPush     (o_canPush),
        .o_canNearPush (o_canNearPush),
        .o_empty       (o_empty),
        .i_cpuRead     (i_cpuRead),
        .o_cpuData     (o_cpuData),
        .i_infoWrite   (i_infoWrite),
        .i_infoData    (i_infoData),
        .o_readyToSend (o_readyToSend),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Monitor: a read strobe sampled at a posedge presents data by the next negedge.
    always @(posedge clk) r_rdSeen <= i_cpuRead && nRst;

    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (r_rdSeen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got %08h expected none", o_cpuData);
            end else begin
                e = exp_q.pop_front();
                check("cpuData", o_cpuData, e);
            end
        end
    end

    // One cycle of stimulus; a read pushes its expected GPUREAD value.
    task automatic drive(input logic wr, input logic [31:0] wd,
                         input logic rd, input logic [31:0] ex,
                         input logic inf, input logic [31:0] id,
                         input logic fl);
        i_write     = wr;
        i_writeData = wd;
        i_cpuRead   = rd;
        i_infoWrite = inf;
        i_infoData  = id;
        i_flush     = fl;
        if (rd) exp_q.push_back(ex);
        @(negedge clk);
        i_write     = 1'b0;
        i_cpuRead   = 1'b0;
        i_infoWrite = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        drive(1'b1, d, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pop(input logic [31:0] ex);
        drive(1'b0, 32'h0, 1'b1, ex, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic flush();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_pass = 0;
        nRst = 1'b0; i_flush = 1'b0; i_write = 1'b0; i_writeData = '0;
        i_cpuRead = 1'b0; i_infoWrite = 1'b0; i_infoData = '0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_empty",   32'(o_empty),       32'd1);
        check("rst_canPush", 32'(o_canPush),     32'd1);
        check("rst_canNear", 32'(o_canNearPush), 32'd1);
        check("rst_ready",   32'(o_readyToSend), 32'd0);
        check("rst_cpuData", o_cpuData,          32'h0);
        check("rst_ovf",     32'(o_overflow),    32'd0);

        // Basic push then pop in order
        for (int i = 0; i < 3; i++) push(32'h1111_0000 + 32'(i));
        check("t2_ready", 32'(o_readyToSend), 32'd1);
        for (int i = 0; i < 3; i++) pop(32'h1111_0000 + 32'(i));
        check("t2_empty", 32'(o_empty), 32'd1);

        // Fill to full from a zeroed pointer pair, checking margin flags
        flush();
        for (int i = 1; i <= 16; i++) begin
            push(32'h2222_0000 + 32'(i - 1));
            check("t3_canPush", 32'(o_canPush),     32'((16 - i) >= 2));
            check("t3_canNear", 32'(o_canNearPush), 32'((16 - i) >= 4));
        end
        check("t3_ovf_full", 32'(o_overflow), 32'd0);

        // Full: simultaneous push and pop, both pointers lap the array
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h3333_0000 + 32'(i), 1'b1, 32'h2222_0000 + 32'(i),
                  1'b0, 32'h0, 1'b0);
            check("t4_full_ovf", 32'(o_overflow), 32'd0);
        end
        check("t4_canPush", 32'(o_canPush), 32'd0);
        check("t4_empty",   32'(o_empty),   32'd0);

        // Push while full is dropped and flagged
        push(32'hBAD0_BAD0);
        check("t3_ovf", 32'(o_overflow), 32'd1);
        for (int i = 0; i < 16; i++) pop(32'h3333_0000 + 32'(i));
        check("t4_drain_empty", 32'(o_empty),    32'd1);
        check("t4_ovf_sticky",  32'(o_overflow), 32'd1);

        // Empty: push and read same cycle sees no data (no fall-through)
        flush();
        check("t5_ovf_cleared", 32'(o_overflow), 32'd0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h3333_000F, 1'b0, 32'h0, 1'b0);
        check("t5_ready", 32'(o_readyToSend), 32'd1);
        pop(32'hDEAD_BEEF);
        check("t5_empty", 32'(o_empty), 32'd1);

        // Info write beats a same-cycle pop, which still consumes the word
        push(32'h1234_5678);
        drive(1'b0, 32'h0, 1'b1, 32'hABCD_0001, 1'b1, 32'hABCD_0001, 1'b0);
        check("info_pop_empty", 32'(o_empty), 32'd1);

        // Flush + read + info in one cycle
        for (int i = 0; i < 5; i++) push(32'h5555_0000 + 32'(i));
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b1);
        check("t6_empty",   32'(o_empty),   32'd1);
        check("t6_canNear", 32'(o_canNearPush), 32'd1);
        pop(32'h0000_0002);

        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
